// File: rtl/multiphase_dpwm.sv
// N-phase interleaved digital PWM: one shared period counter, per-phase phase-shifted
// comparators with dead-time insertion, boundary-latched shadow settings and fast shutdown.
module multiphase_dpwm #(
  parameter int NPHASES  = 4,
  parameter int CNT_W    = 7,
  parameter int DT_W     = 4,
  parameter int DUTY_MAX = 2**CNT_W - 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_pwm,
  input  logic               mode_manual,
  input  logic [CNT_W-1:0]   duty_auto,
  input  logic [CNT_W-1:0]   duty_manual,
  input  logic [DT_W-1:0]    deadtime,
  input  logic [NPHASES-1:0] phase_en,
  output logic [CNT_W-1:0]   count,
  output logic               period_start,
  output logic [NPHASES-1:0] pwm_high,
  output logic [NPHASES-1:0] pwm_low,
  output logic [CNT_W-1:0]   duty_eff
);

  localparam int               PERIOD     = 2**CNT_W;
  localparam int               OFF_STEP   = PERIOD / NPHASES;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_CLAMP = CNT_W'(DUTY_MAX);

  function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
    return (d > DUTY_CLAMP) ? DUTY_CLAMP : d;
  endfunction

  function automatic logic [DT_W-1:0] sat_inc(input logic [DT_W-1:0] r);
    return (r == '1) ? r : r + DT_W'(1);
  endfunction

  logic [DT_W-1:0]    deadtime_q;
  logic [NPHASES-1:0] phase_en_q;
  logic               en_q;
  logic               boundary;
  logic               gate;

  assign boundary     = (count == CNT_LAST);
  assign period_start = (count == '0);
  // en_pwm low kills the outputs on the very next edge, without waiting for the boundary
  assign gate         = en_q & en_pwm;

  // Stage p0: shared counter and shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      duty_eff   <= '0;
      deadtime_q <= '0;
      phase_en_q <= '0;
      en_q       <= 1'b0;
    end else begin
      count <= count + CNT_W'(1);
      if (boundary) begin
        duty_eff   <= clamp_duty(mode_manual ? duty_manual : duty_auto);
        deadtime_q <= deadtime;
        phase_en_q <= phase_en;
        en_q       <= en_pwm;
      end else begin
        en_q <= en_q & en_pwm;
      end
    end
  end

  logic [CNT_W-1:0]   c_loc   [NPHASES];
  logic [DT_W-1:0]    run_q   [NPHASES];
  logic [DT_W-1:0]    run_eff [NPHASES];
  logic [NPHASES-1:0] raw;
  logic [NPHASES-1:0] raw_q;
  logic [NPHASES-1:0] dt_ok;

  // Stage p1: per-phase compare and dead-time qualification
  always_comb begin
    raw   = '0;
    dt_ok = '0;
    for (int k = 0; k < NPHASES; k++) begin
      c_loc[k]   = count - CNT_W'(k * OFF_STEP);
      raw[k]     = (c_loc[k] < duty_eff);
      // the run length restarts in the same cycle the raw level toggles
      run_eff[k] = (raw[k] != raw_q[k]) ? '0 : run_q[k];
      dt_ok[k]   = (run_eff[k] >= deadtime_q);
    end
  end

  // Stage p2: registered gate commands
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q    <= '0;
      pwm_high <= '0;
      pwm_low  <= '0;
      for (int k = 0; k < NPHASES; k++) run_q[k] <= '0;
    end else begin
      raw_q    <= raw;
      pwm_high <= {NPHASES{gate}} & phase_en_q & raw & dt_ok;
      pwm_low  <= {NPHASES{gate}} & phase_en_q & ~raw & dt_ok;
      for (int k = 0; k < NPHASES; k++) run_q[k] <= sat_inc(run_eff[k]);
    end
  end

endmodule

// File: tb/tb_multiphase_dpwm.sv
// Directed bench for multiphase_dpwm (4 phases, 7-bit counter): per-period widths,
// edge positions, boundary latching, shedding, shutdown and reset behaviour.
module tb_multiphase_dpwm;

  localparam int NP = 4;

  logic          clk;
  logic          rst;
  logic          en_pwm;
  logic          mode_manual;
  logic [6:0]    duty_auto;
  logic [6:0]    duty_manual;
  logic [3:0]    deadtime;
  logic [NP-1:0] phase_en;
  logic [6:0]    count;
  logic          period_start;
  logic [NP-1:0] pwm_high;
  logic [NP-1:0] pwm_low;
  logic [6:0]    duty_eff;

  int n_checks = 0;
  int n_err    = 0;
  int hi_cnt  [NP];
  int lo_cnt  [NP];
  int rise_at [NP];
  int overlap;
  int both_low;
  int tail_hi;

  multiphase_dpwm #(.NPHASES(NP), .CNT_W(7), .DT_W(4), .DUTY_MAX(120)) dut (
    .clk(clk), .rst(rst), .en_pwm(en_pwm), .mode_manual(mode_manual),
    .duty_auto(duty_auto), .duty_manual(duty_manual), .deadtime(deadtime),
    .phase_en(phase_en), .count(count), .period_start(period_start),
    .pwm_high(pwm_high), .pwm_low(pwm_low), .duty_eff(duty_eff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_count(input int value);
    int n = 0;
    while (int'(count) != value && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (int'(count) != value) check("wait_count_timeout", int'(count), value);
  endtask

  // Samples one output period: the 128 samples following a count==0 sample
  task automatic measure();
    logic [NP-1:0] prev_h;
    @(negedge clk);
    wait_count(0);
    prev_h   = pwm_high;
    overlap  = 0;
    both_low = 0;
    for (int k = 0; k < NP; k++) begin
      hi_cnt[k] = 0; lo_cnt[k] = 0; rise_at[k] = -1;
    end
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      for (int k = 0; k < NP; k++) begin
        if (pwm_high[k]) hi_cnt[k]++;
        if (pwm_low[k]) lo_cnt[k]++;
        if (pwm_high[k] && pwm_low[k]) overlap++;
        if (!pwm_high[k] && !pwm_low[k]) both_low++;
        if (pwm_high[k] && !prev_h[k] && rise_at[k] < 0) rise_at[k] = int'(count);
      end
      prev_h = pwm_high;
    end
  endtask

  initial begin
    rst = 1'b1; en_pwm = 1'b0; mode_manual = 1'b0;
    duty_auto = '0; duty_manual = '0; deadtime = '0; phase_en = '0;
    repeat (3) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_period_start", int'(period_start), 1);
    check("rst_high", int'(pwm_high), 0);
    check("rst_low", int'(pwm_low), 0);
    check("rst_duty_eff", int'(duty_eff), 0);

    // Interleave, no dead-time
    duty_auto = 7'd32; phase_en = 4'hF; en_pwm = 1'b1; rst = 1'b0;
    @(negedge clk);
    wait_count(127);
    check("pre_boundary_high", int'(pwm_high), 0);
    check("pre_boundary_low", int'(pwm_low), 0);
    measure();
    for (int k = 0; k < NP; k++) begin
      check($sformatf("il_hi%0d", k), hi_cnt[k], 32);
      check($sformatf("il_rise%0d", k), rise_at[k], 32 * k + 1);
    end
    check("il_lo0", lo_cnt[0], 96);
    check("il_lo3", lo_cnt[3], 96);
    check("il_overlap", overlap, 0);
    check("il_both_low", both_low, 0);
    check("il_duty_eff", int'(duty_eff), 32);

    // Dead-time
    duty_auto = 7'd40; deadtime = 4'd5;
    measure(); measure();
    check("dt_hi0", hi_cnt[0], 35);
    check("dt_hi2", hi_cnt[2], 35);
    check("dt_lo1", lo_cnt[1], 83);
    check("dt_lo3", lo_cnt[3], 83);
    check("dt_rise0", rise_at[0], 6);
    check("dt_rise3", rise_at[3], 102);
    check("dt_both_low", both_low, 40);
    check("dt_overlap", overlap, 0);
    check("dt_duty_eff", int'(duty_eff), 40);

    // Boundary latching and clamp
    mode_manual = 1'b1; duty_manual = 7'd20; deadtime = 4'd0;
    measure(); measure();
    check("man_hi0", hi_cnt[0], 20);
    check("man_duty_eff", int'(duty_eff), 20);
    @(negedge clk);
    wait_count(60);
    duty_manual = 7'd127;
    tail_hi = 0;
    for (int i = 0; i < 67; i++) begin
      @(negedge clk);
      if (pwm_high[2]) tail_hi++;
    end
    check("latch_count", int'(count), 127);
    check("latch_tail_hi2", tail_hi, 20);
    check("latch_duty_eff_old", int'(duty_eff), 20);
    @(negedge clk);
    check("clamp_duty_eff", int'(duty_eff), 120);
    measure(); measure();
    check("clamp_hi0", hi_cnt[0], 120);
    check("clamp_hi1", hi_cnt[1], 120);
    check("clamp_lo0", lo_cnt[0], 8);
    check("clamp_overlap", overlap, 0);

    // Phase shedding
    mode_manual = 1'b0; duty_auto = 7'd32;
    measure();
    @(negedge clk);
    wait_count(60);
    phase_en = 4'b0101;
    measure();
    check("shed_hi0", hi_cnt[0], 32);
    check("shed_hi2", hi_cnt[2], 32);
    check("shed_lo2", lo_cnt[2], 96);
    check("shed_hi1", hi_cnt[1], 0);
    check("shed_lo1", lo_cnt[1], 0);
    check("shed_hi3", hi_cnt[3], 0);
    check("shed_lo3", lo_cnt[3], 0);

    // Shutdown and restart
    phase_en = 4'hF;
    measure(); measure();
    @(negedge clk);
    wait_count(50);
    check("sd_before_high", int'(pwm_high), 2);
    check("sd_before_low", int'(pwm_low), 13);
    en_pwm = 1'b0;
    @(negedge clk);
    check("sd_high", int'(pwm_high), 0);
    check("sd_low", int'(pwm_low), 0);
    wait_count(90);
    en_pwm = 1'b1;
    @(negedge clk);
    wait_count(127);
    check("sd_hold_high", int'(pwm_high), 0);
    check("sd_hold_low", int'(pwm_low), 0);
    @(negedge clk);
    check("sd_wrap_high", int'(pwm_high), 0);
    check("sd_wrap_low", int'(pwm_low), 0);
    @(negedge clk);
    check("sd_resume_high", int'(pwm_high), 1);
    check("sd_resume_low", int'(pwm_low), 14);

    // Zero duty
    duty_auto = 7'd0;
    measure(); measure();
    check("d0_hi_sum", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
    check("d0_lo0", lo_cnt[0], 128);
    check("d0_duty_eff", int'(duty_eff), 0);

    // Pulse shorter than dead-time is swallowed
    duty_auto = 7'd10; deadtime = 4'd15;
    measure(); measure();
    check("swallow_hi_sum", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
    check("swallow_lo0", lo_cnt[0], 103);
    check("swallow_overlap", overlap, 0);

    // Reset mid-run
    duty_auto = 7'd32; deadtime = 4'd0;
    measure(); measure();
    @(negedge clk);
    wait_count(20);
    check("mid_high0", int'(pwm_high[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_period_start", int'(period_start), 1);
    check("mid_rst_high", int'(pwm_high), 0);
    check("mid_rst_low", int'(pwm_low), 0);
    check("mid_rst_duty_eff", int'(duty_eff), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
